// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 J/K keyboard decoder: scan codes of
// interest, receiver and decoder state encodings, and a parity helper.
package ps2_pkg;

    // Scan codes (set 2) the decoder reacts to.
    localparam logic [7:0] SC_J     = 8'h3B;
    localparam logic [7:0] SC_K     = 8'h42;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    // Number of data bits in one PS/2 frame.
    localparam int DATA_BITS = 8;

    // Frame receiver states: start bit seen in RX_IDLE, then eight data
    // bits, the parity bit and finally the stop bit.
    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    // Scan-code decoder states: plain, after a break prefix, after an
    // extended prefix, and after an extended break prefix.
    typedef enum logic [1:0] {
        D_WAIT      = 2'd0,
        D_BREAK     = 2'd1,
        D_EXT       = 2'd2,
        D_EXT_BREAK = 2'd3
    } dec_state_t;

    // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises the raw keyboard clock and data into
// the Clk domain, detects falling edges of the keyboard clock, assembles
// start/data/parity/stop frames and guards each frame with an inter-edge
// timeout.
//
// Output handshake: Byte_Valid is a one-cycle strobe with no backpressure;
// Scan_Code is updated on the same edge Byte_Valid rises and is held until
// the next good frame. Frame_Err is a one-cycle strobe for every discarded
// frame. Neither strobe is ever high for two consecutive cycles.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] Scan_Code,
    output logic       Byte_Valid,
    output logic       Frame_Err,
    output rx_state_t  rx_state
);

    // The counter only has to hold 0 .. TIMEOUT_CYCLES-1.
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    // Synchronizer stages; clk_s3 is the previous synchronized clock value
    // used for edge detection. All reset to 1 (the idle line level) so a
    // reset never manufactures a falling edge.
    logic clk_s1, clk_s2, clk_s3;
    logic dat_s1, dat_s2;
    logic fall;

    rx_state_t      state, state_n;
    logic [2:0]     bit_cnt, bit_cnt_n;
    logic [7:0]     shift, shift_n;
    logic           par_bit, par_n;
    logic [TW-1:0]  tmo_cnt, tmo_n;
    logic [7:0]     scan_q, scan_n;
    logic           valid_q, valid_n;
    logic           err_q, err_n;

    // Two-flop synchronizers for both PS/2 lines plus the edge-history flop.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_s3 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= PS2_CLK;
            clk_s2 <= clk_s1;
            clk_s3 <= clk_s2;
            dat_s1 <= PS2_DATA;
            dat_s2 <= dat_s1;
        end
    end

    // A falling edge is a synchronized 1 followed by a synchronized 0.
    assign fall = clk_s3 & ~clk_s2;

    // Receiver state, shift register, timeout counter and output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= RX_IDLE;
            bit_cnt <= 3'd0;
            shift   <= 8'h00;
            par_bit <= 1'b0;
            tmo_cnt <= '0;
            scan_q  <= 8'h00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
            par_bit <= par_n;
            tmo_cnt <= tmo_n;
            scan_q  <= scan_n;
            valid_q <= valid_n;
            err_q   <= err_n;
        end
    end

    // Next-state logic: advance only on a falling edge; while inside a frame
    // count idle cycles and abandon the frame when the gap gets too long.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        par_n     = par_bit;
        tmo_n     = tmo_cnt;
        scan_n    = scan_q;
        valid_n   = 1'b0;
        err_n     = 1'b0;

        if (fall) begin
            tmo_n = '0;
            case (state)
                RX_IDLE: begin
                    // A high start bit is line noise; stay put silently.
                    if (!dat_s2) begin
                        state_n   = RX_DATA;
                        bit_cnt_n = 3'd0;
                    end
                end
                RX_DATA: begin
                    // LSB arrives first, so shift in from the top.
                    shift_n   = {dat_s2, shift[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'(DATA_BITS - 1)) begin
                        state_n = RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    par_n   = dat_s2;
                    state_n = RX_STOP;
                end
                RX_STOP: begin
                    state_n = RX_IDLE;
                    if (dat_s2 && odd_parity_ok(shift, par_bit)) begin
                        scan_n  = shift;
                        valid_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                default: begin
                    state_n = RX_IDLE;
                end
            endcase
        end else if (state != RX_IDLE) begin
            if (tmo_cnt == TMO_LAST) begin
                state_n = RX_IDLE;
                tmo_n   = '0;
                err_n   = 1'b1;
            end else begin
                tmo_n = tmo_cnt + TW'(1);
            end
        end else begin
            tmo_n = '0;
        end
    end

    assign Scan_Code  = scan_q;
    assign Byte_Valid = valid_q;
    assign Frame_Err  = err_q;
    assign rx_state   = state;

endmodule

// File: rtl/ps2_jk_decoder.sv
// PS/2 keyboard decoder that tracks the J and K keys as held levels for the
// fighter-animation FSM. The frame receiver delivers bytes; the decoder FSM
// here interprets make, break (F0) and extended (E0) sequences.
module ps2_jk_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic       J_Press,
    output logic       K_Press,
    output logic [7:0] Scan_Code,
    output logic       Byte_Valid,
    output logic       Frame_Err,
    output rx_state_t  dbg_rx_state,
    output dec_state_t dbg_dec_state
);

    logic [7:0] rx_byte;
    logic       rx_valid;

    dec_state_t dec, dec_n;
    logic       j_q, j_n;
    logic       k_q, k_n;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_rx (
        .Clk        (Clk),
        .Reset      (Reset),
        .PS2_CLK    (PS2_CLK),
        .PS2_DATA   (PS2_DATA),
        .Scan_Code  (rx_byte),
        .Byte_Valid (rx_valid),
        .Frame_Err  (Frame_Err),
        .rx_state   (dbg_rx_state)
    );

    // Decoder state and the two key levels; levels move one cycle after Byte_Valid.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            dec <= D_WAIT;
            j_q <= 1'b0;
            k_q <= 1'b0;
        end else begin
            dec <= dec_n;
            j_q <= j_n;
            k_q <= k_n;
        end
    end

    // Scan-code interpretation: only good bytes move the FSM, so receiver
    // errors leave any half-seen prefix intact. Repeat makes rewrite a 1 with
    // a 1, which keeps held levels glitch-free.
    always_comb begin
        dec_n = dec;
        j_n   = j_q;
        k_n   = k_q;

        if (rx_valid) begin
            case (dec)
                D_WAIT: begin
                    if (rx_byte == SC_BREAK) begin
                        dec_n = D_BREAK;
                    end else if (rx_byte == SC_EXT) begin
                        dec_n = D_EXT;
                    end else begin
                        if (rx_byte == SC_J) j_n = 1'b1;
                        if (rx_byte == SC_K) k_n = 1'b1;
                    end
                end
                D_BREAK: begin
                    dec_n = D_WAIT;
                    if (rx_byte == SC_J) j_n = 1'b0;
                    if (rx_byte == SC_K) k_n = 1'b0;
                end
                D_EXT: begin
                    // Extended keys share codes with J/K but are different keys.
                    dec_n = (rx_byte == SC_BREAK) ? D_EXT_BREAK : D_WAIT;
                end
                D_EXT_BREAK: begin
                    dec_n = D_WAIT;
                end
                default: begin
                    dec_n = D_WAIT;
                end
            endcase
        end
    end

    assign J_Press       = j_q;
    assign K_Press       = k_q;
    assign Scan_Code     = rx_byte;
    assign Byte_Valid    = rx_valid;
    assign dbg_dec_state = dec;

endmodule

// File: tb/tb_ps2_jk_decoder.sv
// Testbench for ps2_jk_decoder: directed J/K scenarios followed by random
// frames, with a scoreboard fed by a sequence-level reference model.
module tb_ps2_jk_decoder;

  localparam int T    = 200;  // timeout used for this bench
  localparam int HALF = 10;   // Clk cycles per PS/2 clock half period

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic PS2_CLK = 1'b1;
  logic PS2_DATA = 1'b1;

  logic       J_Press, K_Press, Byte_Valid, Frame_Err;
  logic [7:0] Scan_Code;
  ps2_pkg::rx_state_t  dbg_rx_state;
  ps2_pkg::dec_state_t dbg_dec_state;

  ps2_jk_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .PS2_CLK       (PS2_CLK),
    .PS2_DATA      (PS2_DATA),
    .J_Press       (J_Press),
    .K_Press       (K_Press),
    .Scan_Code     (Scan_Code),
    .Byte_Valid    (Byte_Valid),
    .Frame_Err     (Frame_Err),
    .dbg_rx_state  (dbg_rx_state),
    .dbg_dec_state (dbg_dec_state)
  );

  always #5 Clk = ~Clk;

  int unsigned cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 100000", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // ---------------- scoreboard state ----------------
  logic [9:0]  exp_q[$];        // {k, j, scan} expected per good frame
  int          exp_errs = 0;    // discarded frames still expected
  logic        cur_j = 1'b0, cur_k = 1'b0;
  logic [7:0]  cur_scan = 8'h00;
  logic        mon_on = 1'b0;
  int unsigned err_cyc = 0;
  int          n_err_seen = 0;
  int unsigned last_fall_cyc = 0;

  // ---------------- reference model ----------------
  // Key semantics: a byte is a make unless preceded by F0 (break) or E0
  // (extended); E0 F0 x is an extended break. Only plain J/K codes matter.
  logic [7:0] pre[$];
  logic       mj = 1'b0, mk = 1'b0;

  task automatic model_frame(input logic [7:0] b, input logic bad_par, input logic stop);
    if (bad_par || !stop) begin
      exp_errs++;
      return;
    end
    if (pre.size() == 0) begin
      if (b == 8'hF0 || b == 8'hE0) pre.push_back(b);
      else begin
        if (b == 8'h3B) mj = 1'b1;
        if (b == 8'h42) mk = 1'b1;
      end
    end else if (pre.size() == 1 && pre[0] == 8'hF0) begin
      if (b == 8'h3B) mj = 1'b0;
      if (b == 8'h42) mk = 1'b0;
      pre.delete();
    end else if (pre.size() == 1 && b == 8'hF0) begin
      pre.push_back(b);
    end else begin
      pre.delete();
    end
    exp_q.push_back({mk, mj, b});
  endtask

  // ---------------- driver tasks ----------------
  task automatic ps2_bit(input logic b);
    @(negedge Clk);
    PS2_DATA = b;
    repeat (HALF) @(negedge Clk);
    PS2_CLK = 1'b0;
    last_fall_cyc = cyc;
    repeat (HALF) @(negedge Clk);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
    model_frame(b, bad_par, stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(stop);
    repeat (4) @(negedge Clk);
    PS2_DATA = 1'b1;
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [9:0] e;
    logic bv_prev, fe_prev;
    bv_prev = 1'b0;
    fe_prev = 1'b0;
    forever begin
      @(negedge Clk);
      if (mon_on) begin
        check("j_level", J_Press, cur_j);
        check("k_level", K_Press, cur_k);
        if (bv_prev) check("byte_valid_width", Byte_Valid, 0);
        else if (Byte_Valid) begin
          if (exp_q.size() == 0) check("unexpected_byte_valid", Byte_Valid, 0);
          else begin
            e = exp_q.pop_front();
            check("scan_on_valid", Scan_Code, e[7:0]);
            cur_scan = e[7:0];
            cur_j = e[8];
            cur_k = e[9];
          end
        end
        if (!Byte_Valid) check("scan_hold", Scan_Code, cur_scan);
        if (fe_prev) check("frame_err_width", Frame_Err, 0);
        else if (Frame_Err) begin
          check("frame_err_expected", exp_errs > 0, 1);
          if (exp_errs > 0) exp_errs--;
          err_cyc = cyc;
          n_err_seen++;
        end
        bv_prev = Byte_Valid;
        fe_prev = Frame_Err;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [7:0]  b;
    logic        bp, st;
    int          n0, waited, r;
    int unsigned d;

    repeat (3) @(negedge Clk);
    check("reset_j", J_Press, 0);
    check("reset_k", K_Press, 0);
    check("reset_scan", Scan_Code, 0);
    check("reset_valid", Byte_Valid, 0);
    check("reset_err", Frame_Err, 0);
    #1 Reset = 1'b0;
    mon_on = 1'b1;
    repeat (5) @(negedge Clk);

    // Stray edge with a high "start" bit must be ignored.
    ps2_bit(1'b1);
    repeat (5) @(negedge Clk);

    // J make, then K make while J held, then release J.
    send_frame(8'h3B, 1'b0, 1'b1);
    check("j_after_make", J_Press, 1);
    check("k_after_j_make", K_Press, 0);
    send_frame(8'h42, 1'b0, 1'b1);
    check("combo_j", J_Press, 1);
    check("combo_k", K_Press, 1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h3B, 1'b0, 1'b1);
    check("j_after_break", J_Press, 0);
    check("k_after_j_break", K_Press, 1);

    // Bad parity must not touch Scan_Code or the key levels.
    send_frame(8'h3B, 1'b0, 1'b1);
    send_frame(8'h42, 1'b0, 1'b1);
    n0 = n_err_seen;
    send_frame(8'h3B, 1'b1, 1'b1);
    check("bad_parity_err_count", n_err_seen - n0, 1);
    check("bad_parity_scan", Scan_Code, 8'h42);
    check("bad_parity_j", J_Press, 1);

    // Timeout after start + 4 data bits.
    n0 = n_err_seen;
    b = 8'h42;
    exp_errs++;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(b[i]);
    waited = 0;
    while (n_err_seen == n0 && waited < T + 50) begin
      @(negedge Clk);
      waited++;
    end
    check("timeout_err_count", n_err_seen - n0, 1);
    d = err_cyc - last_fall_cyc;
    n_checks++;
    if (n_err_seen != n0 && d >= T && d <= T + 3) n_pass++;
    else $display("FAIL timeout_latency: got %0d cycles required %0d..%0d", d, T, T + 3);
    send_frame(8'h42, 1'b0, 1'b1);
    check("after_timeout_drained", exp_q.size(), 0);

    // Extended break of 3B must not release J; repeats keep J high.
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h3B, 1'b0, 1'b1);
    check("j_after_ext_break", J_Press, 1);
    for (int i = 0; i < 3; i++) send_frame(8'h3B, 1'b0, 1'b1);
    check("j_after_repeats", J_Press, 1);

    // Bad stop bit.
    send_frame(8'h55, 1'b0, 1'b0);

    // Reset in the middle of a frame with J held.
    check("j_before_reset", J_Press, 1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(negedge Clk);
    #1 Reset = 1'b1;
    cur_j = 1'b0;
    cur_k = 1'b0;
    cur_scan = 8'h00;
    mj = 1'b0;
    mk = 1'b0;
    pre.delete();
    @(negedge Clk);
    check("midreset_j", J_Press, 0);
    check("midreset_k", K_Press, 0);
    check("midreset_scan", Scan_Code, 0);
    check("midreset_valid", Byte_Valid, 0);
    check("midreset_err", Frame_Err, 0);
    #1 Reset = 1'b0;
    n0 = n_err_seen;
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h3B, 1'b0, 1'b1);
    check("post_reset_j", J_Press, 0);
    check("post_reset_no_err", n_err_seen - n0, 0);

    // Random frames.
    for (int n = 0; n < 100; n++) begin
      case ($urandom_range(0, 5))
        0: b = 8'h3B;
        1: b = 8'h42;
        2: b = 8'hF0;
        3: b = 8'hE0;
        default: b = 8'($urandom_range(0, 255));
      endcase
      r = $urandom_range(0, 11);
      bp = (r == 0);
      st = (r != 1);
      send_frame(b, bp, st);
      repeat ($urandom_range(0, 5)) @(negedge Clk);
    end

    repeat (20) @(negedge Clk);
    check("final_byte_queue_empty", exp_q.size(), 0);
    check("final_err_queue_empty", exp_errs, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_jk_decoder.md
PS2_JK_DECODER -- requirements
Module: ps2_jk_decoder

Interface
REQ-001 The block SHALL use the parameter TIMEOUT_CYCLES, default 50000, which sets the maximum number of Clk cycles allowed between PS/2 falling edges inside a frame (1 ms at 50 MHz).
REQ-002 Clk  input  1  system clock, 50 MHz.
REQ-003 Reset  input  1  synchronous, active-high reset, sampled on posedge Clk.
REQ-004 PS2_CLK  input  1  raw keyboard clock, asynchronous to Clk.
REQ-005 PS2_DATA  input  1  raw keyboard data, asynchronous to Clk.
REQ-006 J_Press  output  1  level, high while the J key is held; drives the fighter-animation FSM.
REQ-007 K_Press  output  1  level, high while the K key is held; drives the fighter-animation FSM.
REQ-008 Scan_Code  output  8  last valid received byte, held until the next valid byte.
REQ-009 Byte_Valid  output  1  one-cycle pulse when Scan_Code updates.
REQ-010 Frame_Err  output  1  one-cycle pulse when a frame is discarded.

Function
REQ-011 PS2_CLK and PS2_DATA SHALL each pass through a 2-flop synchronizer; a falling edge SHALL be a synchronized 1 followed by a synchronized 0.
REQ-012 The frame receiver SHALL sample synchronized PS2_DATA only on a detected falling edge.
REQ-013 The frame format SHALL be: start=0, 8 data bits LSB first, odd parity, stop=1.
REQ-014 The receiver FSM SHALL have these states: RX_IDLE -> RX_DATA (8 edges) -> RX_PARITY -> RX_STOP -> RX_IDLE.
REQ-015 In RX_IDLE, a sampled start bit of 1 SHALL be ignored: the FSM stays in RX_IDLE and no error is raised.
REQ-016 When a stop bit of 1 is sampled and parity is good, Scan_Code SHALL update and Byte_Valid SHALL pulse on the next posedge Clk (latency 1 cycle from the stop edge).
REQ-017 A parity mismatch or a stop bit of 0 SHALL discard the byte and pulse Frame_Err; Scan_Code SHALL remain unchanged.
REQ-018 A gap of TIMEOUT_CYCLES cycles with no falling edge while not in RX_IDLE SHALL return the FSM to RX_IDLE and pulse Frame_Err; the timeout counter SHALL reset on every falling edge.
REQ-019 The decoder FSM SHALL have the states D_WAIT, D_BREAK, D_EXT and D_EXT_BREAK, and SHALL advance only on Byte_Valid.
REQ-020 From D_WAIT, the decoder SHALL go to D_BREAK on 0xF0, to D_EXT on 0xE0, and on any other byte SHALL treat the byte as a make code and stay in D_WAIT.
REQ-021 A make code of 0x3B SHALL set J_Press, and a make code of 0x42 SHALL set K_Press.
REQ-022 From D_BREAK, the decoder SHALL always return to D_WAIT; a byte of 0x3B SHALL clear J_Press and a byte of 0x42 SHALL clear K_Press.
REQ-023 From D_EXT, the decoder SHALL go to D_EXT_BREAK on 0xF0 and otherwise to D_WAIT; from D_EXT_BREAK it SHALL return to D_WAIT; extended codes SHALL never change J_Press or K_Press.
REQ-024 Typematic repeat makes SHALL leave an already-set press level unchanged, with no glitch.
REQ-025 The J and K states SHALL be independent, so both may be high at once, giving the J&K combo.
REQ-026 A Frame_Err in the receiver SHALL NOT change the decoder state.
REQ-027 J_Press and K_Press SHALL be registered outputs that change on the posedge after Byte_Valid.

Reset
REQ-028 Reset SHALL force J_Press=0, K_Press=0, Scan_Code=0x00, Byte_Valid=0 and Frame_Err=0.
REQ-029 Reset SHALL put the receiver FSM in RX_IDLE, the decoder FSM in D_WAIT, and clear the timeout counter and the synchronizers (to 1).
REQ-030 Reset asserted mid-frame SHALL discard the partial frame without a Frame_Err pulse; the remaining bits of that frame are then handled per REQ-015 and REQ-018.

Structure
REQ-031 The shared package ps2_pkg SHALL hold: SC_J=8'h3B, SC_K=8'h42, SC_BREAK=8'hF0, SC_EXT=8'hE0, and the rx_state_t and dec_state_t enums.
REQ-032 The design SHALL use one sub-module, ps2_frame_rx (synchronizers, edge detect, receiver FSM, timeout), which outputs Scan_Code, Byte_Valid and Frame_Err; the decoder FSM resides in ps2_jk_decoder.

Verification
REQ-033 The bench SHALL send frame 0x3B (parity 0) and require Byte_Valid=1 for exactly 1 cycle, Scan_Code=0x3B, and J_Press=1 on the following cycle with K_Press=0.
REQ-034 The bench SHALL send 0x42 (parity 1) while J is held and require J_Press=1 and K_Press=1; it SHALL then send F0 (parity 1) followed by 3B and require J_Press=0 and K_Press=1.
REQ-035 The bench SHALL send 0x3B with parity 1 and require Frame_Err to pulse once, Byte_Valid to stay 0, and J_Press and Scan_Code to be unchanged.
REQ-036 The bench SHALL stop PS2_CLK after 4 data bits and require Frame_Err exactly TIMEOUT_CYCLES cycles (+sync latency ≤3) after the last edge; a following full 0x42 frame SHALL then decode correctly.
REQ-037 The bench SHALL send E0, F0, 3B with J held and require J_Press to stay 1; it SHALL then send three repeat 0x3B makes and require J_Press=1 with no low cycle.
REQ-038 The bench SHALL assert Reset for 1 cycle mid-frame with J_Press=1 and require all outputs to be 0, then a clean F0/3B sequence to leave J_Press=0 with no Frame_Err.
